// File: rtl/elevator_call_latch.sv
// elevator_call_latch
// Front end for the elevator controller. Raw floor-call buttons are synchronized,
// debounced and latched as sticky pending calls that drive the controller's
// ra..rd request inputs. When the car reaches a floor that has a pending call,
// the call is cleared and the door is held open for a fixed dwell.

module elevator_call_latch #(
    parameter int DEB_CYCLES   = 4,
    parameter int DWELL_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic [1:0] floor,
    output logic       ra,
    output logic       rb,
    output logic       rc,
    output logic       rd,
    output logic [3:0] pending,
    output logic       door_open
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int DW = $clog2(DWELL_CYCLES + 1);

    localparam logic [CW-1:0] DEB_MAX    = CW'(DEB_CYCLES);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [CW-1:0] cnt [4];
    logic [3:0]    press;

    logic [DW-1:0] dwell_cnt;
    logic [DW-1:0] dwell_cnt_nxt;
    logic [1:0]    dwell_floor;
    logic [1:0]    dwell_floor_nxt;
    logic [3:0]    pending_nxt;
    logic          door_open_nxt;
    logic [3:0]    floor_mask;

    assign floor_mask = 4'b0001 << floor;

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 4'b0000;
            s2 <= 4'b0000;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Saturating debounce counters; any low cycle restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!s2[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] < DEB_MAX) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // A press is the single edge on which a counter reaches DEB_CYCLES.
    always_comb begin
        press = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            press[i] = s2[i] && (cnt[i] == DEB_LAST);
        end
    end

    // Service FSM next-state: latch presses, serve the current floor, time the dwell.
    always_comb begin
        state_nxt       = state;
        dwell_cnt_nxt   = dwell_cnt;
        dwell_floor_nxt = dwell_floor;
        door_open_nxt   = door_open;
        pending_nxt     = pending | press;
        case (state)
            IDLE: begin
                door_open_nxt = 1'b0;
                if (pending[floor]) begin
                    state_nxt       = DWELL;
                    pending_nxt     = (pending | press) & ~floor_mask;
                    dwell_cnt_nxt   = DWELL_LOAD;
                    dwell_floor_nxt = floor;
                    door_open_nxt   = 1'b1;
                end
            end
            DWELL: begin
                pending_nxt   = pending | (press & ~floor_mask);
                door_open_nxt = 1'b1;
                if (floor != dwell_floor) begin
                    state_nxt     = IDLE;
                    door_open_nxt = 1'b0;
                    dwell_cnt_nxt = '0;
                end else if (dwell_cnt == '0) begin
                    state_nxt     = IDLE;
                    door_open_nxt = 1'b0;
                end else begin
                    dwell_cnt_nxt = dwell_cnt - DW'(1);
                end
            end
            default: begin
                state_nxt     = IDLE;
                door_open_nxt = 1'b0;
            end
        endcase
    end

    // Service FSM state, dwell timer, pending calls and door flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            dwell_cnt   <= '0;
            dwell_floor <= 2'b00;
            pending     <= 4'b0000;
            door_open   <= 1'b0;
        end else begin
            state       <= state_nxt;
            dwell_cnt   <= dwell_cnt_nxt;
            dwell_floor <= dwell_floor_nxt;
            pending     <= pending_nxt;
            door_open   <= door_open_nxt;
        end
    end

    assign ra = pending[0] & ~door_open;
    assign rb = pending[1] & ~door_open;
    assign rc = pending[2] & ~door_open;
    assign rd = pending[3] & ~door_open;

endmodule

// File: tb/tb_elevator_call_latch.sv
// tb_elevator_call_latch
// Directed vectors against hand-computed expectations for the call latch:
// reset, debounce, serve, clear-vs-set, abort and asynchronous reset mid-dwell.

module tb_elevator_call_latch;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic [1:0] floor;
    logic       ra;
    logic       rb;
    logic       rc;
    logic       rd;
    logic [3:0] pending;
    logic       door_open;

    int vectorCount;
    int missCount;

    elevator_call_latch #(
        .DEB_CYCLES  (4),
        .DWELL_CYCLES(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .floor    (floor),
        .ra       (ra),
        .rb       (rb),
        .rc       (rc),
        .rd       (rd),
        .pending  (pending),
        .door_open(door_open)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] b, input logic [1:0] f);
        btn   = b;
        floor = f;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        rst = 1'b0;
        applyStimulus(4'h0, 2'd0);
        tick(2);
        rst = 1'b1;
    endtask

    function automatic logic [31:0] reqs();
        return 32'({rd, rc, rb, ra});
    endfunction

    // Directed test sequence.
    initial begin
        vectorCount = 0;
        missCount   = 0;
        rst         = 1'b0;
        applyStimulus(4'hF, 2'd0);

        // Reset held with all buttons pressed.
        tick(3);
        checkOutput("rst_pending", 32'(pending), 32'h0);
        checkOutput("rst_door", 32'(door_open), 32'h0);
        checkOutput("rst_reqs", reqs(), 32'h0);
        rst = 1'b1;
        tick(5);
        checkOutput("rel_pending_e4", 32'(pending), 32'h0);
        tick(1);
        checkOutput("rel_pending_e5", 32'(pending), 32'hF);
        checkOutput("rel_reqs_e5", reqs(), 32'hF);
        checkOutput("rel_door_e5", 32'(door_open), 32'h0);
        tick(1);
        checkOutput("rel_door_e6", 32'(door_open), 32'h1);
        checkOutput("rel_pending_e6", 32'(pending), 32'hE);
        checkOutput("rel_reqs_masked", reqs(), 32'h0);
        tick(7);
        checkOutput("rel_door_e13", 32'(door_open), 32'h1);
        tick(1);
        checkOutput("rel_door_e14", 32'(door_open), 32'h0);
        checkOutput("rel_reqs_e14", reqs(), 32'hE);

        // Debounce: 3-cycle pulse, 1 low, then a held press.
        doReset();
        applyStimulus(4'h4, 2'd0);
        tick(3);
        applyStimulus(4'h0, 2'd0);
        tick(1);
        checkOutput("deb_after_glitch", 32'(pending), 32'h0);
        applyStimulus(4'h4, 2'd0);
        tick(5);
        checkOutput("deb_edge4", 32'(pending), 32'h0);
        tick(1);
        checkOutput("deb_edge5", 32'(pending), 32'h4);
        applyStimulus(4'h2, 2'd0);
        tick(3);
        applyStimulus(4'h0, 2'd0);
        tick(8);
        checkOutput("deb_glitch_only", 32'(pending), 32'h4);

        // Serve floor 3 from floor 1.
        doReset();
        applyStimulus(4'h8, 2'd1);
        tick(6);
        checkOutput("srv_pending", 32'(pending), 32'h8);
        checkOutput("srv_rd", 32'(rd), 32'h1);
        applyStimulus(4'h0, 2'd3);
        tick(1);
        checkOutput("srv_door_entry", 32'(door_open), 32'h1);
        checkOutput("srv_pending_clr", 32'(pending), 32'h0);
        checkOutput("srv_rd_clr", 32'(rd), 32'h0);
        tick(7);
        checkOutput("srv_door_last", 32'(door_open), 32'h1);
        tick(1);
        checkOutput("srv_door_closed", 32'(door_open), 32'h0);

        // Clear beats a same-edge press; same-floor press in dwell is dropped.
        doReset();
        applyStimulus(4'h1, 2'd1);
        tick(6);
        checkOutput("cvs_pending0", 32'(pending), 32'h1);
        checkOutput("cvs_ra", 32'(ra), 32'h1);
        applyStimulus(4'h0, 2'd1);
        tick(2);
        applyStimulus(4'h1, 2'd1);
        tick(5);
        applyStimulus(4'h1, 2'd0);
        tick(1);
        checkOutput("cvs_entry_pending", 32'(pending), 32'h0);
        checkOutput("cvs_entry_door", 32'(door_open), 32'h1);
        applyStimulus(4'h0, 2'd0);
        tick(1);
        applyStimulus(4'h5, 2'd0);
        tick(6);
        checkOutput("cvs_dwell_pending", 32'(pending), 32'h4);
        checkOutput("cvs_dwell_door", 32'(door_open), 32'h1);
        tick(1);
        checkOutput("cvs_close_door", 32'(door_open), 32'h0);
        checkOutput("cvs_close_reqs", reqs(), 32'h4);
        tick(1);
        checkOutput("cvs_no_reentry", 32'(door_open), 32'h0);

        // Abort dwell at floor 2 by moving to floor 1, then serve floor 1.
        doReset();
        applyStimulus(4'h6, 2'd0);
        tick(6);
        checkOutput("abt_pending", 32'(pending), 32'h6);
        applyStimulus(4'h6, 2'd2);
        tick(1);
        checkOutput("abt_entry_door", 32'(door_open), 32'h1);
        tick(2);
        applyStimulus(4'h6, 2'd1);
        tick(1);
        checkOutput("abt_door_drop", 32'(door_open), 32'h0);
        checkOutput("abt_reqs", reqs(), 32'h2);
        tick(1);
        checkOutput("abt_serve1_door", 32'(door_open), 32'h1);
        checkOutput("abt_serve1_pending", 32'(pending), 32'h0);

        // Asynchronous reset in the middle of a dwell.
        doReset();
        applyStimulus(4'hB, 2'd0);
        tick(6);
        checkOutput("ard_pending", 32'(pending), 32'hB);
        tick(1);
        checkOutput("ard_entry_pending", 32'(pending), 32'hA);
        checkOutput("ard_entry_door", 32'(door_open), 32'h1);
        tick(4);
        rst = 1'b0;
        #2;
        checkOutput("ard_async_pending", 32'(pending), 32'h0);
        checkOutput("ard_async_door", 32'(door_open), 32'h0);
        checkOutput("ard_async_reqs", reqs(), 32'h0);
        tick(2);
        applyStimulus(4'h0, 2'd0);
        rst = 1'b1;
        tick(10);
        checkOutput("ard_after_pending", 32'(pending), 32'h0);
        checkOutput("ard_after_door", 32'(door_open), 32'h0);
        checkOutput("ard_after_reqs", reqs(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
